// File: rtl/fetch_controller.sv
// Instruction fetch FSM: requests a word from instruction memory, holds it for decode, and strobes the PC load.
// Define FETCH_TIMEOUT_EN to add a fetch-timeout counter with a sticky fetch_err flag and an absorbing ERR state.
module fetch_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        areset,
  input  logic        start,
  input  logic        halt,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch_taken,
  output logic        PCSrc,
  output logic        load,
  output logic [31:0] instr_count,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_instr;
  logic [31:0] r_instr_count;
  logic        w_accept;
  logic        w_timeout;

  assign imem_req    = (r_state == FETCH);
  assign instr_valid = (r_state == HOLD);
  assign w_accept    = instr_valid & instr_ready;
  // Reset masks the PC strobes immediately, before the state register clears.
  assign load        = w_accept & ~areset;
  assign PCSrc       = load & branch_taken;
  assign instr       = r_instr;
  assign instr_count = r_instr_count;

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_timeout;
  logic          r_fetch_err;

  // An ack arriving in the limit cycle wins, so the timeout only fires without one.
  assign w_timeout = (r_state == FETCH) && !imem_ack && (r_timeout == CW'(TIMEOUT_CYCLES));
  assign fetch_err = r_fetch_err;

  always_ff @(posedge clk) begin
    if (areset) begin
      r_timeout   <= '0;
      r_fetch_err <= 1'b0;
    end else begin
      if (r_state != FETCH && w_next == FETCH) begin
        r_timeout <= '0;
      end else if (r_state == FETCH && !imem_ack && r_timeout != CW'(TIMEOUT_CYCLES)) begin
        r_timeout <= r_timeout + 1'b1;
      end
      if (w_timeout) begin
        r_fetch_err <= 1'b1;
      end
    end
  end
`else
  assign w_timeout = 1'b0;
  assign fetch_err = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start && !halt) w_next = FETCH;
      end
      FETCH: begin
        if (imem_ack)       w_next = HOLD;
        else if (w_timeout) w_next = ERR;
      end
      HOLD: begin
        if (w_accept) w_next = halt ? IDLE : FETCH;
      end
      ERR: begin
        w_next = ERR;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      r_state       <= IDLE;
      r_instr       <= '0;
      r_instr_count <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == FETCH && imem_ack) begin
        r_instr <= imem_rdata;
      end
      if (w_accept) begin
        r_instr_count <= r_instr_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: directed fetches push expected accepts, a negedge monitor checks them.
// The timeout scenario is compiled in only when FETCH_TIMEOUT_EN is defined.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        areset;
  logic        start;
  logic        halt;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_taken;
  logic        PCSrc;
  logic        load;
  logic [31:0] instr_count;
  logic        fetch_err;

  typedef struct {
    logic [31:0] instr;
    logic        pcsrc;
    logic [31:0] count;
  } exp_t;

  exp_t        expQ[$];
  exp_t        monE;
  exp_t        pushE;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] expCount = 32'd0;
  logic        pendingCount = 1'b0;
  logic [31:0] pendingCountVal = 32'd0;

  always #5 clk = ~clk;

  fetch_controller #(.TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .areset      (areset),
    .start       (start),
    .halt        (halt),
    .imem_req    (imem_req),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .branch_taken(branch_taken),
    .PCSrc       (PCSrc),
    .load        (load),
    .instr_count (instr_count),
    .fetch_err   (fetch_err)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic checkFlag(input string name, input logic actual, input logic expected);
    checkOutput(name, 32'(actual), 32'(expected));
  endtask

  task automatic stepCycle;
    @(posedge clk);
    #1;
  endtask

  // Starts in FETCH: ack rdata, stall in HOLD, then accept with the given branch/halt inputs.
  task automatic applyStimulus(input logic [31:0] rdata, input logic branch, input int stallCycles,
                               input logic haltAtAccept, input logic preload);
    checkFlag("fetch.imem_req", imem_req, 1'b1);
    imem_ack     = 1'b1;
    imem_rdata   = rdata;
    instr_ready  = 1'b0;
    branch_taken = 1'b0;
    stepCycle();
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEADBEEF;
    checkFlag("hold.instr_valid", instr_valid, 1'b1);
    checkOutput("hold.instr", instr, rdata);
    if (preload) begin
      force dut.r_instr_count = 32'hFFFFFFFF;
      #1;
      release dut.r_instr_count;
      expCount = 32'hFFFFFFFF;
    end
    for (int i = 0; i < stallCycles; i++) begin
      instr_ready  = 1'b0;
      branch_taken = 1'b1;
      #1;
      checkFlag("stall.load", load, 1'b0);
      checkFlag("stall.PCSrc", PCSrc, 1'b0);
      stepCycle();
      checkOutput("stall.instr", instr, rdata);
      checkFlag("stall.instr_valid", instr_valid, 1'b1);
    end
    expCount    = expCount + 32'd1;
    pushE.instr = rdata;
    pushE.pcsrc = branch;
    pushE.count = expCount;
    expQ.push_back(pushE);
    instr_ready  = 1'b1;
    branch_taken = branch;
    halt         = haltAtAccept;
    stepCycle();
    instr_ready  = 1'b0;
    branch_taken = 1'b0;
    halt         = 1'b0;
    checkFlag("post_accept.instr_valid", instr_valid, 1'b0);
    checkFlag("post_accept.imem_req", imem_req, !haltAtAccept);
  endtask

  // Monitor: every load pulse must match the next expected accept; the count is checked one edge later.
  always @(negedge clk) begin
    if (pendingCount) begin
      checkOutput("mon.instr_count", instr_count, pendingCountVal);
      pendingCount = 1'b0;
    end
    if (load === 1'b1) begin
      checkFlag("mon.load_in_hold", instr_valid, 1'b1);
      if (expQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL mon.unexpected_load: got load=1, expected no accept");
      end else begin
        monE = expQ.pop_front();
        checkOutput("mon.instr", instr, monE.instr);
        checkFlag("mon.PCSrc", PCSrc, monE.pcsrc);
        pendingCount    = 1'b1;
        pendingCountVal = monE.count;
      end
    end else begin
      checkFlag("mon.PCSrc_without_load", PCSrc, 1'b0);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset with competing start/ack/ready asserted to show reset priority.
    areset       = 1'b1;
    start        = 1'b1;
    halt         = 1'b0;
    imem_ack     = 1'b1;
    imem_rdata   = 32'hCAFEF00D;
    instr_ready  = 1'b1;
    branch_taken = 1'b1;
    stepCycle();
    stepCycle();
    checkFlag("reset.imem_req", imem_req, 1'b0);
    checkFlag("reset.instr_valid", instr_valid, 1'b0);
    checkOutput("reset.instr", instr, 32'd0);
    checkOutput("reset.instr_count", instr_count, 32'd0);
    checkFlag("reset.fetch_err", fetch_err, 1'b0);
    checkFlag("reset.load", load, 1'b0);
    checkFlag("reset.PCSrc", PCSrc, 1'b0);

    areset       = 1'b0;
    imem_ack     = 1'b0;
    instr_ready  = 1'b0;
    branch_taken = 1'b0;
    stepCycle();
    start = 1'b0;

    applyStimulus(32'h00500093, 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(32'h00C0006F, 1'b1, 0, 1'b0, 1'b0);
    applyStimulus(32'h00208133, 1'b0, 5, 1'b1, 1'b0);

    // IDLE ignores a stray ack.
    imem_ack   = 1'b1;
    imem_rdata = 32'h12345678;
    stepCycle();
    imem_ack = 1'b0;
    checkFlag("idle_ack.imem_req", imem_req, 1'b0);
    checkFlag("idle_ack.instr_valid", instr_valid, 1'b0);
    checkOutput("idle_ack.instr", instr, 32'h00208133);

    // Halt wins over start in IDLE.
    start = 1'b1;
    halt  = 1'b1;
    stepCycle();
    checkFlag("halt_wins.imem_req", imem_req, 1'b0);
    halt = 1'b0;
    stepCycle();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkFlag("wait_ack.imem_req", imem_req, 1'b1);
      checkFlag("wait_ack.instr_valid", instr_valid, 1'b0);
      stepCycle();
    end

    applyStimulus(32'h00000013, 1'b0, 2, 1'b0, 1'b1);

    // Reset while an accept is pending must mask load/PCSrc.
    imem_ack   = 1'b1;
    imem_rdata = 32'hABCDEF01;
    stepCycle();
    imem_ack = 1'b0;
    checkFlag("gate.instr_valid", instr_valid, 1'b1);
    areset       = 1'b1;
    instr_ready  = 1'b1;
    branch_taken = 1'b1;
    #1;
    checkFlag("gate.load", load, 1'b0);
    checkFlag("gate.PCSrc", PCSrc, 1'b0);
    stepCycle();
    checkFlag("gate.instr_valid_after", instr_valid, 1'b0);
    checkOutput("gate.instr_after", instr, 32'd0);
    checkOutput("gate.instr_count_after", instr_count, 32'd0);
    areset       = 1'b0;
    instr_ready  = 1'b0;
    branch_taken = 1'b0;
    expCount     = 32'd0;

    // Reset mid-FETCH, then a late ack.
    start = 1'b1;
    stepCycle();
    start = 1'b0;
    checkFlag("midfetch.imem_req", imem_req, 1'b1);
    areset      = 1'b1;
    imem_ack    = 1'b1;
    imem_rdata  = 32'h55AA55AA;
    instr_ready = 1'b1;
    stepCycle();
    checkFlag("midfetch.imem_req_dropped", imem_req, 1'b0);
    checkOutput("midfetch.instr", instr, 32'd0);
    areset = 1'b0;
    stepCycle();
    imem_ack    = 1'b0;
    instr_ready = 1'b0;
    checkFlag("late_ack.imem_req", imem_req, 1'b0);
    checkFlag("late_ack.instr_valid", instr_valid, 1'b0);
    checkOutput("late_ack.instr", instr, 32'd0);

`ifdef FETCH_TIMEOUT_EN
    start = 1'b1;
    stepCycle();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checkFlag("timeout.imem_req", imem_req, 1'b1);
      checkFlag("timeout.fetch_err_early", fetch_err, 1'b0);
      stepCycle();
    end
    checkFlag("timeout.limit_imem_req", imem_req, 1'b1);
    checkFlag("timeout.limit_fetch_err", fetch_err, 1'b0);
    stepCycle();
    checkFlag("timeout.fetch_err", fetch_err, 1'b1);
    checkFlag("timeout.imem_req_off", imem_req, 1'b0);
    start       = 1'b1;
    imem_ack    = 1'b1;
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkFlag("err.load", load, 1'b0);
      stepCycle();
      checkFlag("err.imem_req", imem_req, 1'b0);
      checkFlag("err.instr_valid", instr_valid, 1'b0);
      checkFlag("err.fetch_err", fetch_err, 1'b1);
    end
    start       = 1'b0;
    imem_ack    = 1'b0;
    instr_ready = 1'b0;
    areset      = 1'b1;
    stepCycle();
    areset   = 1'b0;
    expCount = 32'd0;
    checkFlag("err_reset.fetch_err", fetch_err, 1'b0);

    start = 1'b1;
    stepCycle();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      stepCycle();
    end
    applyStimulus(32'h00100073, 1'b0, 0, 1'b1, 1'b0);
    checkFlag("late_limit_ack.fetch_err", fetch_err, 1'b0);
`endif

    stepCycle();
    stepCycle();
    checkOutput("end.queue_empty", 32'(expQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
